// File: rtl/hc4e_pkg.sv
// Shared constants and loader state encoding for the HC4e memory-side responder.
package hc4e_pkg;

  localparam int PC_W   = 8;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;

  localparam logic [PC_W-1:0] NOP_OP = 8'hE1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } loader_state_t;

endpackage

// File: rtl/hc4e_strobe_sync.sv
// N-stage synchroniser for an active-low strobe, with a rising-edge (strobe release) pulse.
module hc4e_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic nReset,
  input  logic i_strobe_n,
  output logic o_level_n,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // NOTE: non-blocking assignments make every stage sample its neighbour's old value.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_strobe_n};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level_n = r_sync[STAGES-1];
  assign o_rise    = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/hc4e_memsys.sv
// HC4e memory-side responder: program RAM fetch, 16x4 data RAM, host program loader.
// Build option HC4E_MEM_CLEAR_EN: zero the data RAM with a 16-cycle sweep on every LOAD entry.
module hc4e_memsys
  import hc4e_pkg::*;
#(
  parameter int    SYNC_STAGES   = 2,
  parameter int    RESET_HOLD    = 4,
  parameter string ROM_INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic [PC_W-1:0]   pc_in,
  output logic [PC_W-1:0]   instruction,
  input  logic [ADDR_W-1:0] address_bus,
  inout  wire  [DATA_W-1:0] data_bus,
  input  logic              nRAM_RD,
  input  logic              nRAM_WR,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [7:0]        prog_data,
  output logic              prog_ready,
  output logic              load_full,
  output logic              cpu_nReset
);

  localparam logic [7:0] HOLD_INIT = 8'(RESET_HOLD);

  logic [PC_W-1:0]   r_prog_mem [256];
  logic [DATA_W-1:0] r_dram     [16];

  loader_state_t     r_state;
  logic [7:0]        r_load_addr;
  logic              r_load_full;
  logic              r_prog_ready;
  logic [7:0]        r_hold_cnt;
  logic [PC_W-1:0]   r_instruction;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
`ifdef HC4E_MEM_CLEAR_EN
  logic              r_clr_active;
  logic [ADDR_W-1:0] r_clr_addr;
`endif

  logic w_accept;
  logic w_wr_level_n;
  logic w_wr_rise;
  logic w_commit;

  hc4e_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clock      (clock),
    .nReset     (nReset),
    .i_strobe_n (nRAM_WR),
    .o_level_n  (w_wr_level_n),
    .o_rise     (w_wr_rise)
  );

  // prog_ready is only ever high in LOAD, so it alone qualifies a host write.
  assign w_accept = prog_valid & r_prog_ready;
  assign w_commit = w_wr_rise & (r_state == ST_RUN);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state      <= ST_RUN;
      r_load_addr  <= '0;
      r_load_full  <= 1'b0;
      r_prog_ready <= 1'b0;
      r_hold_cnt   <= '0;
`ifdef HC4E_MEM_CLEAR_EN
      r_clr_active <= 1'b0;
      r_clr_addr   <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_load_addr <= r_load_addr + 8'd1;
        if (r_load_addr == 8'hFF) r_load_full <= 1'b1;
      end
      if (prog_mode && r_state != ST_LOAD) begin
        r_state     <= ST_LOAD;
        r_load_addr <= '0;
        r_load_full <= 1'b0;
`ifdef HC4E_MEM_CLEAR_EN
        r_prog_ready <= 1'b0;
        r_clr_active <= 1'b1;
        r_clr_addr   <= '0;
`else
        r_prog_ready <= 1'b1;
`endif
      end else begin
        case (r_state)
          ST_LOAD: begin
`ifdef HC4E_MEM_CLEAR_EN
            if (r_clr_active) begin
              r_clr_addr <= r_clr_addr + 4'd1;
              if (r_clr_addr == 4'hF) begin
                r_clr_active <= 1'b0;
                r_prog_ready <= 1'b1;
              end
            end else if (!prog_mode) begin
`else
            if (!prog_mode) begin
`endif
              r_state      <= ST_HOLD;
              r_prog_ready <= 1'b0;
              r_hold_cnt   <= HOLD_INIT;
            end
          end
          ST_HOLD: begin
            // Leaving on the count of 1 means the decremented value reaches 0 as RUN begins.
            r_hold_cnt <= r_hold_cnt - 8'd1;
            if (r_hold_cnt == 8'd1) r_state <= ST_RUN;
          end
          default: r_state <= ST_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_instruction <= NOP_OP;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
    end else begin
      r_instruction <= (r_state == ST_RUN) ? r_prog_mem[pc_in] : NOP_OP;
      if (!w_wr_level_n) begin
        r_wr_addr <= address_bus;
        r_wr_data <= data_bus;
      end
    end
  end

  // NOTE: memories carry no reset; their write ports live in clock-only blocks.
  always_ff @(posedge clock) begin
    if (w_accept) r_prog_mem[r_load_addr] <= prog_data;
  end

  always_ff @(posedge clock) begin
`ifdef HC4E_MEM_CLEAR_EN
    if (r_clr_active) r_dram[r_clr_addr] <= '0;
    else if (w_commit) r_dram[r_wr_addr] <= r_wr_data;
`else
    if (w_commit) r_dram[r_wr_addr] <= r_wr_data;
`endif
  end

  assign data_bus    = (!nRAM_RD && r_state == ST_RUN) ? r_dram[address_bus] : 'z;
  assign instruction = r_instruction;
  assign prog_ready  = r_prog_ready;
  assign load_full   = r_load_full;
  assign cpu_nReset  = nReset & (r_state == ST_RUN);

endmodule

// File: tb/tb_hc4e_memsys.sv
// Scoreboard bench for hc4e_memsys: stimulus queues expectations, a negedge monitor checks them.
module tb_hc4e_memsys;

  localparam int RH = 4;
  localparam int SS = 2;
`ifdef HC4E_MEM_CLEAR_EN
  localparam int CLR_CYCLES = 16;
`else
  localparam int CLR_CYCLES = 0;
`endif

  logic       clock = 1'b0;
  logic       nReset;
  logic [7:0] pc_in;
  wire  [7:0] instruction;
  logic [3:0] address_bus;
  wire  [3:0] data_bus;
  logic       nRAM_RD, nRAM_WR;
  logic       prog_mode, prog_valid;
  logic [7:0] prog_data;
  wire        prog_ready, load_full, cpu_nReset;

  logic       bus_drive;
  logic [3:0] bus_val;
  assign data_bus = bus_drive ? bus_val : 4'bz;

  hc4e_memsys #(.SYNC_STAGES(SS), .RESET_HOLD(RH)) dut (
    .clock       (clock),
    .nReset      (nReset),
    .pc_in       (pc_in),
    .instruction (instruction),
    .address_bus (address_bus),
    .data_bus    (data_bus),
    .nRAM_RD     (nRAM_RD),
    .nRAM_WR     (nRAM_WR),
    .prog_mode   (prog_mode),
    .prog_valid  (prog_valid),
    .prog_data   (prog_data),
    .prog_ready  (prog_ready),
    .load_full   (load_full),
    .cpu_nReset  (cpu_nReset)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef enum {K_INSTR, K_BUS, K_CPURST, K_READY, K_FULL} kind_t;
  typedef struct {
    int         due;
    kind_t      kind;
    logic [7:0] exp;
    int         tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tag_n = 0;

  // Reference model: memory images plus loader bookkeeping.
  logic [7:0] m_prog [256];
  logic [3:0] m_dram [16];
  int         m_addr;
  int         m_count;

  task automatic check(kind_t k, int tag, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s#%0d at cycle %0d: got %02h, expected %02h", k.name(), tag, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] actual(kind_t k);
    case (k)
      K_INSTR:  return instruction;
      K_BUS:    return {4'h0, data_bus};
      K_CPURST: return {7'h0, cpu_nReset};
      K_READY:  return {7'h0, prog_ready};
      default:  return {7'h0, load_full};
    endcase
  endfunction

  always @(negedge clock) begin : monitor
    exp_t keep[$];
    keep = {};
    foreach (sb_q[i]) begin
      if (sb_q[i].due <= cyc) check(sb_q[i].kind, sb_q[i].tag, actual(sb_q[i].kind), sb_q[i].exp);
      else keep.push_back(sb_q[i]);
    end
    sb_q = keep;
  end

  task automatic expect_at(kind_t k, int lat, logic [7:0] v);
    exp_t e;
    e.due  = cyc + lat;
    e.kind = k;
    e.exp  = v;
    e.tag  = tag_n++;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enter_load();
    prog_mode = 1'b1;
    tick();
    m_addr  = 0;
    m_count = 0;
    if (CLR_CYCLES > 0) for (int a = 0; a < 16; a++) m_dram[a] = 4'h0;
    for (int k = 0; k < CLR_CYCLES; k++) begin
      expect_at(K_READY, 0, 8'h00);
      tick();
    end
    expect_at(K_READY, 0, 8'h01);
    expect_at(K_CPURST, 0, 8'h00);
  endtask

  task automatic model_byte(logic [7:0] b);
    prog_valid = 1'b1;
    prog_data  = b;
    m_prog[m_addr] = b;
    m_addr  = (m_addr + 1) % 256;
    m_count++;
  endtask

  task automatic send_byte(logic [7:0] b);
    model_byte(b);
    tick();
    expect_at(K_INSTR, 0, 8'hE1);
    if (m_count >= 255 && m_count <= 257) expect_at(K_FULL, 0, 8'(m_count >= 256));
    prog_valid = 1'b0;
  endtask

  task automatic send_random(int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      send_byte(b);
    end
  endtask

  task automatic exit_load(bit with_byte);
    logic [7:0] b;
    prog_mode = 1'b0;
    if (with_byte) begin
      b = 8'($urandom);
      model_byte(b);
    end
    tick();
    prog_valid = 1'b0;
    for (int k = 0; k < RH; k++) begin
      expect_at(K_CPURST, 0, 8'h00);
      if (k == 0) expect_at(K_READY, 0, 8'h00);
      tick();
    end
    expect_at(K_CPURST, 0, 8'h01);
  endtask

  task automatic fetch(logic [7:0] pc);
    pc_in = pc;
    expect_at(K_INSTR, 1, m_prog[pc]);
    tick();
  endtask

  task automatic dram_write(logic [3:0] a, logic [3:0] d, bit in_run);
    address_bus = a;
    bus_val     = d;
    bus_drive   = 1'b1;
    nRAM_WR     = 1'b0;
    repeat (10) tick();
    nRAM_WR = 1'b1;
    repeat (SS + 4) tick();
    bus_drive = 1'b0;
    if (in_run) m_dram[a] = d;
  endtask

  task automatic dram_read(logic [3:0] a);
    address_bus = a;
    nRAM_RD     = 1'b0;
    expect_at(K_BUS, 0, {4'h0, m_dram[a]});
    tick();
    nRAM_RD = 1'b1;
  endtask

  // The DUT must release the bus: a bench-driven value then reads back unchanged.
  task automatic bus_released(logic rd_n, logic [3:0] v);
    nRAM_RD   = rd_n;
    bus_val   = v;
    bus_drive = 1'b1;
    expect_at(K_BUS, 0, {4'h0, v});
    tick();
    bus_drive = 1'b0;
    nRAM_RD   = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] wa [6];
    logic [3:0] wd;
    nReset = 1'b0; pc_in = 8'h00; address_bus = 4'h0;
    nRAM_RD = 1'b1; nRAM_WR = 1'b1; prog_mode = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
    bus_drive = 1'b0; bus_val = 4'h0; m_addr = 0; m_count = 0;

    // Reset values.
    tick();
    expect_at(K_INSTR, 0, 8'hE1);
    expect_at(K_READY, 0, 8'h00);
    expect_at(K_FULL, 0, 8'h00);
    expect_at(K_CPURST, 0, 8'h00);
    tick();
    nReset = 1'b1;
    expect_at(K_CPURST, 0, 8'h01);
    tick();

    // Basic load of A1, B2, C3 followed by the reset hold and fetches.
    enter_load();
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    exit_load(1'b0);
    fetch(8'd1);
    fetch(8'd0);
    fetch(8'd2);

    // Data RAM write through the synchroniser, then asynchronous read.
    dram_write(4'd5, 4'd9, 1'b1);
    dram_read(4'd5);
    bus_released(1'b1, 4'h6);
    for (int i = 0; i < 6; i++) begin
      wa[i] = 4'($urandom);
      wd    = 4'($urandom);
      dram_write(wa[i], wd, 1'b1);
    end
    for (int i = 0; i < 6; i++) dram_read(wa[i]);

    // Retention or clear across a load; strobes during LOAD must not commit.
    dram_write(4'd3, 4'd7, 1'b1);
    enter_load();
    dram_write(4'd3, 4'hA, 1'b0);
    expect_at(K_INSTR, 0, 8'hE1);
    bus_released(1'b0, 4'h5);
    send_random(5);
    exit_load(1'b1);
    dram_read(4'd3);
    dram_read(4'd5);
    for (int i = 0; i < 6; i++) fetch(8'(i));

    // Wrap: 257 bytes, full on the 256th accept, byte 257 lands at 0.
    enter_load();
    send_random(257);
    exit_load(1'b0);
    fetch(8'd0);
    fetch(8'd255);
    for (int i = 0; i < 8; i++) fetch(8'($urandom));

    // Asynchronous reset in the middle of a load.
    enter_load();
    send_random(3);
    prog_valid = 1'b1;
    prog_data  = ~m_prog[3];
    nReset     = 1'b0;
    expect_at(K_READY, 0, 8'h00);
    expect_at(K_CPURST, 0, 8'h00);
    tick();
    tick();
    expect_at(K_FULL, 0, 8'h00);
    prog_valid = 1'b0;
    prog_mode  = 1'b0;
    nReset     = 1'b1;
    expect_at(K_CPURST, 0, 8'h01);
    expect_at(K_INSTR, 0, 8'hE1);
    tick();
    for (int i = 0; i < 5; i++) fetch(8'(i));

    repeat (3) tick();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
